// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory responder for the tartaruga memory stage.
// One outstanding load/store, response after LATENCY cycles, held until consumed.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (flag and suppress misaligned accesses).

package tartaruga_pkg;
  typedef logic [31:0] bus32_t;
endpackage

module dmem_responder
  import tartaruga_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_valid_i,
  output logic   req_ready_o,
  input  logic   req_write_i,
  input  bus32_t req_addr_i,
  input  bus32_t req_wdata_i,
  output logic   resp_valid_o,
  input  logic   resp_ready_i,
  output bus32_t resp_rdata_o,
  output logic   resp_err_o
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            r_ready;
  logic            r_resp_valid;
  bus32_t          r_rdata;
  logic            r_err;
  bus32_t          r_pend_data;
  logic            r_pend_err;
  bus32_t          r_mem [DMEM_WORDS];

  logic            w_accept;
  logic            w_misalign;
  logic            w_wr;
  logic [AW-1:0]   w_idx;
  bus32_t          w_acc_data;
  bus32_t          w_resp_data;
  logic            w_resp_err;
  logic            w_unused_addr;

  assign w_idx         = req_addr_i[AW+1:2];
  assign w_unused_addr = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = |req_addr_i[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept    = (r_state == S_IDLE) && r_ready && req_valid_i;
  assign w_wr        = rst_n && w_accept && req_write_i && !w_misalign;
  assign w_acc_data  = (req_write_i || w_misalign) ? 32'd0 : r_mem[w_idx];
  // With LATENCY==1 the response is built straight from the accepting request.
  assign w_resp_data = (r_state == S_IDLE) ? w_acc_data : r_pend_data;
  assign w_resp_err  = (r_state == S_IDLE) ? w_misalign : r_pend_err;

  // Next-state and latency counter decode.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_next = CW'(LATENCY - 1);
          w_next     = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_next = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, handshake outputs and response registers; outputs are zero outside RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_pend_data  <= '0;
      r_pend_err   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_ready      <= (w_next == S_IDLE);
      r_resp_valid <= (w_next == S_RESP);
      r_rdata      <= (w_next == S_RESP) ? w_resp_data : 32'd0;
      r_err        <= (w_next == S_RESP) ? w_resp_err : 1'b0;
      if (w_accept) begin
        r_pend_data <= w_acc_data;
        r_pend_err  <= w_misalign;
      end
    end
  end

  // Storage array; contents survive reset so committed stores stay visible.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_idx] <= req_wdata_i;
  end

  assign req_ready_o  = r_ready;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2, DMEM_WORDS=1024).
// Honours DMEM_MISALIGN_CHECK_EN when choosing expected results.

module tb_dmem_responder;

  localparam int unsigned WORDS = 1024;
  localparam int unsigned LAT   = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  int          n_checks;
  int          n_fail;
  rsp_t        sb[$];
  logic [31:0] model [WORDS];

  dmem_responder #(.DMEM_WORDS(WORDS), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_mis(input logic [31:0] addr);
`ifdef DMEM_MISALIGN_CHECK_EN
    return |addr[1:0];
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour: returns expected response and updates the model.
  function automatic rsp_t model_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    rsp_t r;
    logic [9:0] idx;
    idx = addr[11:2];
    r.err  = is_mis(addr);
    r.data = 32'd0;
    if (!r.err) begin
      if (wr) model[idx] = wdata;
      else    r.data = model[idx];
    end
    return r;
  endfunction

  // Wait (bounded) for req_ready_o at a falling edge.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(req_ready_o), 32'd1);
  endtask

  // One full transaction; hold>0 keeps resp_ready_i low that many cycles and pokes a stray request.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    rsp_t r;
    int   lat;
    resp_ready_i = (hold == 0);
    wait_ready();
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    sb.push_back(model_op(wr, addr, wdata));
    @(negedge clk);
    req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 20) begin
      chk("rdata_zero_wait", resp_rdata_o, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    r = sb.pop_front();
    chk("rdata", resp_rdata_o, r.data);
    chk("err", 32'(resp_err_o), 32'(r.err));
    for (int i = 0; i < hold; i++) begin
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_addr_i  = addr;
      req_wdata_i = 32'hFFFF_0000;
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid_o), 32'd1);
      chk("bp_rdata", resp_rdata_o, r.data);
      chk("bp_err", 32'(resp_err_o), 32'(r.err));
      chk("bp_ready", 32'(req_ready_o), 32'd0);
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    @(negedge clk);
    chk("back_idle_ready", 32'(req_ready_o), 32'd1);
    chk("back_idle_valid", 32'(resp_valid_o), 32'd0);
    chk("back_idle_rdata", resp_rdata_o, 32'd0);
  endtask

  // Accept a request, then assert reset in the following cycle.
  task automatic rst_mid(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    rsp_t r;
    wait_ready();
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    r = model_op(wr, addr, wdata);
    @(negedge clk);
    req_valid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready_o), 32'd0);
    chk("mid_rst_valid", 32'(resp_valid_o), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_resp", 32'(resp_valid_o), 32'd0);
    end
    chk("mid_rst_ready_after", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    req_valid_i  = 1'b0;
    req_write_i  = 1'b0;
    req_addr_i   = 32'd0;
    req_wdata_i  = 32'd0;
    resp_ready_i = 1'b1;
    for (int i = 0; i < int'(WORDS); i++) model[i] = 32'hx;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_err", 32'(resp_err_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready_o), 32'd1);
    chk("post_rst_valid", 32'(resp_valid_o), 32'd0);

    // Basic store/load.
    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    txn(1'b0, 32'h0000_0010, 32'h0, 0);
    txn(1'b1, 32'h0000_0014, 32'h1234_5678, 0);
    txn(1'b0, 32'h0000_0014, 32'h0, 0);

    // Upper address bits alias onto the same word.
    txn(1'b1, 32'h1000_0010, 32'hA5A5_A5A5, 0);
    txn(1'b0, 32'h0000_0010, 32'h0, 0);

    // Backpressure with a stray request that must not be consumed.
    txn(1'b0, 32'h0000_0010, 32'h0, 5);
    txn(1'b0, 32'h0000_0010, 32'h0, 0);

    // Reset mid-transaction: load dropped, earlier store committed.
    rst_mid(1'b0, 32'h0000_0014, 32'h0);
    rst_mid(1'b1, 32'h0000_0018, 32'h55AA_55AA);
    txn(1'b0, 32'h0000_0018, 32'h0, 0);

    // Misaligned access handling.
    txn(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 0);
    txn(1'b1, 32'h0000_0022, 32'h1111_1111, 0);
    txn(1'b0, 32'h0000_0020, 32'h0, 0);
    txn(1'b0, 32'h0000_0023, 32'h0, 0);

    // Randomised traffic over a small initialised window.
    for (int i = 0; i < 8; i++) txn(1'b1, 32'h40 + 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = 32'h40 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
